seq_pattern_tx: RTL and testbench

Bit-serial pattern transmitter: the sending end of the serial bit stream that the sequence detectors in the FSM library consume. It captures a parallel pattern word and shifts it out one bit per clock. The pattern is repeated a programmable number of times, with idle gap cycles between repetitions. It provides the controllable stimulus and link source for the overlapping/non-overlapping detectors on `seq_in`.

---
 rtl/seq_pattern_tx.sv | 181 ++++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter.
// It captures a parallel pattern word on start and shifts it out MSB-first,
// starting at bit len-1. The pattern repeats rep_in+1 times, with GAP_CYCLES
// idle cycles between repetitions. Every output comes from a flop.
// Optional feature: define SEQ_TX_PARITY_EN to append one even-parity bit
// after bit 0 of every repetition.
module seq_pattern_tx #(
  parameter int WIDTH      = 14,
  parameter int LEN_W      = 5,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic             stall,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int               GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] len_eff;
  logic             end_of_rep;
  logic             seq_out_d;
`ifdef SEQ_TX_PARITY_EN
  logic             par_phase_q, par_phase_d;
  logic             par_bit_q, par_bit_d;
  logic [WIDTH-1:0] len_mask;
`endif

  // A length of 0, or anything beyond WIDTH, selects the full word.
  assign len_eff = (len_in == '0 || len_in > WIDTH_L) ? WIDTH_L : len_in;

`ifdef SEQ_TX_PARITY_EN
  // Keep only the L low bits of the word when computing parity.
  assign len_mask = {WIDTH{1'b1}} >> (WIDTH_L - len_eff);
`endif

  // Next-state logic: capture, bit countdown, repetition and gap sequencing.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    end_of_rep = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    par_phase_d = par_phase_q;
    par_bit_d   = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          pat_d   = data_in;
          len_d   = len_eff;
          idx_d   = len_eff - LEN_W'(1);
          rep_d   = rep_in;
          gap_d   = '0;
`ifdef SEQ_TX_PARITY_EN
          par_phase_d = 1'b0;
          par_bit_d   = ^(data_in & len_mask);
`endif
        end
      end
      SHIFT: begin
        if (!stall) begin
`ifdef SEQ_TX_PARITY_EN
          if (par_phase_q)        end_of_rep  = 1'b1;
          else if (idx_q == '0)   par_phase_d = 1'b1;
          else                    idx_d       = idx_q - LEN_W'(1);
`else
          if (idx_q == '0) end_of_rep = 1'b1;
          else             idx_d      = idx_q - LEN_W'(1);
`endif
          if (end_of_rep) begin
`ifdef SEQ_TX_PARITY_EN
            par_phase_d = 1'b0;
`endif
            if (rep_q == '0) begin
              state_d = DONE;
            end else begin
              // The next repetition restarts at the top bit, whether or not a gap precedes it.
              rep_d = rep_q - CNT_W'(1);
              idx_d = len_q - LEN_W'(1);
              if (GAP_CYCLES > 0) begin
                state_d = GAP;
                gap_d   = GAP_W'(GAP_CYCLES - 1);
              end
            end
          end
        end
      end
      GAP: begin
        if (!stall) begin
          if (gap_q == '0) state_d = SHIFT;
          else             gap_d   = gap_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serial bit for the coming cycle, taken from the next-state values so the registered output lines up with the state.
  always_comb begin
    seq_out_d = 1'b0;
    if (state_d == SHIFT) begin
      seq_out_d = |(pat_d & (WIDTH'(1) << idx_d));
`ifdef SEQ_TX_PARITY_EN
      if (par_phase_d) seq_out_d = par_bit_d;
`endif
    end
  end

  // State, captured pattern, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      seq_out   <= 1'b0;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_phase_q <= 1'b0;
      par_bit_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      seq_out   <= seq_out_d;
      seq_valid <= (state_d == SHIFT);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
`ifdef SEQ_TX_PARITY_EN
      par_phase_q <= par_phase_d;
      par_bit_q   <= par_bit_d;
`endif
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a directed vector table, a
// mid-pattern reset sequence, and randomized transactions compared cycle by
// cycle against an expected-stream model built from the transmitter's rules.
module tb_seq_pattern_tx;

  localparam int WIDTH = 14;
  localparam int LEN_W = 5;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [LEN_W-1:0] len_in = '0;
  logic [CNT_W-1:0] rep_in = '0;
  logic             stall = 1'b0;
  logic             seq_out, seq_valid, busy, done;
  logic [1:0]       state_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] rep;
    int               stall_at;    // stall when this many valid bits have been seen (0 = never)
    int               stall_len;
    int               restart_at;  // extra start pulse after this many valid bits (0 = never)
    logic [63:0]      exp_bits;
    int               exp_n;
    int               exp_cycles;  // busy cycles before the DONE cycle
  } vec_t;

  typedef struct packed {
    logic [1:0] st;
    logic       v;
    logic       b;
  } ent_t;

  vec_t tbl[7];

  seq_pattern_tx #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .len_in(len_in), .rep_in(rep_in), .stall(stall), .seq_out(seq_out),
    .seq_valid(seq_valid), .busy(busy), .done(done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {state_out, busy, done, seq_valid, seq_out};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Runs one transaction and collects the valid bits and busy-cycle count.
  task automatic run_direct(input vec_t v, output logic [63:0] bits, output int nbits, output int cycles);
    int stall_left;
    bit stall_done;
    int n;
    bits = '0; nbits = 0; cycles = 0; stall_left = 0; stall_done = 0; n = 0;
    @(negedge clk);
    data_in = v.data; len_in = v.len; rep_in = v.rep; start = 1'b1; stall = 1'b0;
    @(negedge clk);
    start = 1'b0; data_in = ~v.data; len_in = 5'd1; rep_in = 4'd0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) cycles++;
      if (seq_valid === 1'b1) begin
        bits = {bits[62:0], seq_out};
        nbits++;
      end
      start = (v.restart_at > 0) && (nbits == v.restart_at);
      if (v.stall_at > 0 && !stall_done && nbits == v.stall_at) begin
        stall = 1'b1; stall_left = v.stall_len; stall_done = 1'b1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end
      @(negedge clk);
      n++;
      if (n > 300) begin
        n_errors++;
        $display("FAIL %s_timeout: no done after %0d cycles", v.name, n);
        break;
      end
    end
    stall = 1'b0;
    // A start raised during the DONE cycle must be ignored.
    start = 1'b1;
    @(negedge clk);
    check({v.name, "_done_then_idle"}, 64'(obs()), 64'(0));
    start = 1'b0;
  endtask

  // Random transaction checked cycle by cycle against the expected-stream model.
  task automatic run_random(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l, input logic [CNT_W-1:0] r);
    ent_t q[$];
    ent_t cur;
    int   len_e;
    logic pbit;
    int   p;
    int   iter;
    len_e = (l == 0 || int'(l) > WIDTH) ? WIDTH : int'(l);
    pbit = 1'b0;
    for (int i = 0; i < len_e; i++) pbit ^= d[i];
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = len_e - 1; i >= 0; i--) q.push_back('{2'd1, 1'b1, d[i]});
      if (PAR) q.push_back('{2'd1, 1'b1, pbit});
      if (k < int'(r)) for (int g = 0; g < GAP; g++) q.push_back('{2'd2, 1'b0, 1'b0});
    end
    q.push_back('{2'd3, 1'b0, 1'b0});
    q.push_back('{2'd0, 1'b0, 1'b0});
    @(negedge clk);
    data_in = d; len_in = l; rep_in = r; start = 1'b1; stall = 1'($urandom);
    @(negedge clk);
    p = 0; iter = 0;
    while (p < q.size()) begin
      cur = q[p];
      check("rand_cycle", 64'(obs()),
            64'({cur.st, (cur.st != 2'd0), (cur.st == 2'd3), cur.v, cur.b}));
      stall   = ($urandom_range(3) == 0);
      start   = (cur.st != 2'd0) && ($urandom_range(3) == 0);
      data_in = WIDTH'($urandom);
      len_in  = LEN_W'($urandom);
      rep_in  = CNT_W'($urandom);
      @(negedge clk);
      if (!(stall && (cur.st == 2'd1 || cur.st == 2'd2))) p++;
      iter++;
      if (iter > 3000) begin
        n_errors++;
        $display("FAIL rand_timeout: stream not finished after %0d cycles", iter);
        break;
      end
    end
    start = 1'b0; stall = 1'b0;
  endtask

  initial begin
    logic [63:0] bits;
    int          nbits;
    int          cycles;

`ifdef SEQ_TX_PARITY_EN
    tbl[0] = '{"basic",  14'b00110001010101, 5'd0,  4'd0,  0, 0, 0, 64'(15'b001100010101010), 15, 15};
    tbl[1] = '{"gap",    14'h000B,           5'd4,  4'd2,  0, 0, 0, 64'(15'b101111011110111), 15, 19};
    tbl[2] = '{"clamp",  14'h2A5B,           5'd20, 4'd0,  0, 0, 3, 64'({14'h2A5B, 1'b0}),    15, 15};
    tbl[3] = '{"len1",   14'h2AA1,           5'd1,  4'd3,  0, 0, 0, 64'(8'b11111111),         8,  14};
    tbl[4] = '{"len3",   14'h3FF5,           5'd3,  4'd1,  0, 0, 0, 64'(8'b10101010),         8,  10};
    tbl[5] = '{"stall",  14'b00110001010101, 5'd0,  4'd0,  5, 3, 0, 64'({17'b00110000001010101, 1'b0}), 18, 18};
    tbl[6] = '{"rep15",  14'h0002,           5'd2,  4'd15, 0, 0, 0, 64'({16{3'b101}}),        48, 78};
`else
    tbl[0] = '{"basic",  14'b00110001010101, 5'd0,  4'd0,  0, 0, 0, 64'(14'b00110001010101),  14, 14};
    tbl[1] = '{"gap",    14'h000B,           5'd4,  4'd2,  0, 0, 0, 64'(12'b101110111011),    12, 16};
    tbl[2] = '{"clamp",  14'h2A5B,           5'd20, 4'd0,  0, 0, 3, 64'(14'h2A5B),            14, 14};
    tbl[3] = '{"len1",   14'h2AA1,           5'd1,  4'd3,  0, 0, 0, 64'(4'b1111),             4,  10};
    tbl[4] = '{"len3",   14'h3FF5,           5'd3,  4'd1,  0, 0, 0, 64'(6'b101101),           6,  8};
    tbl[5] = '{"stall",  14'b00110001010101, 5'd0,  4'd0,  5, 3, 0, 64'(17'b00110000001010101), 17, 17};
    tbl[6] = '{"rep15",  14'h0002,           5'd2,  4'd15, 0, 0, 0, 64'({16{2'b10}}),         32, 62};
`endif

    // Reset values, then idle after release.
    #1;
    check("reset_outputs", 64'(obs()), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'(obs()), 64'(0));

    // Directed vector table.
    for (int t = 0; t < 7; t++) begin
      run_direct(tbl[t], bits, nbits, cycles);
      check({tbl[t].name, "_bits"},   bits,          tbl[t].exp_bits);
      check({tbl[t].name, "_nbits"},  64'(nbits),    64'(tbl[t].exp_n));
      check({tbl[t].name, "_cycles"}, 64'(cycles),   64'(tbl[t].exp_cycles));
    end

    // Reset asserted while bit 7 of a basic send is on the line.
    @(negedge clk);
    data_in = 14'b00110001010101; len_in = 5'd0; rep_in = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("bit7_before_reset", 64'(obs()), 64'({2'b01, 1'b1, 1'b0, 1'b1, 1'b0}));
    #2 reset_n = 1'b0;
    #1 check("reset_async", 64'(obs()), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_reset_release", 64'(obs()), 64'(0));
    end

    // Randomized transactions with stalls, start noise and changing inputs.
    for (int t = 0; t < 40; t++) begin
      run_random(WIDTH'($urandom), LEN_W'($urandom_range(0, 20)), CNT_W'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
